// File: rtl/lms_adapt_ctrl.sv
// Step-size scheduler and convergence monitor for the 16-tap LMS adaptive FIR.
// Optional mu annealing in COARSE is enabled by defining LMS_MU_ANNEAL_EN.
module lms_adapt_ctrl #(
    parameter int unsigned E_W       = 33,
    parameter int unsigned WIN_LOG2  = 6,
    parameter int unsigned FLUSH_CYC = 16,
    parameter int unsigned MU_COARSE = 4,
    parameter int unsigned MU_FINE   = 8,
    parameter int unsigned MU_FREEZE = 40,
    parameter int unsigned CONV_WINS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic signed [E_W-1:0]         e_in,
    input  logic [E_W-2+WIN_LOG2:0]       thr_conv,
    input  logic [E_W-2+WIN_LOG2:0]       thr_div,
    output logic                          filt_rst_n,
    output logic [7:0]                    mu_out,
    output logic [2:0]                    state_out,
    output logic                          converged,
    output logic                          diverged,
    output logic [E_W-2+WIN_LOG2:0]       win_energy
);

    localparam int unsigned ACC_W = E_W - 1 + WIN_LOG2;
    localparam int unsigned MAG_W = E_W - 1;
    localparam int unsigned FL_W  = $clog2(FLUSH_CYC + 1);
    localparam int unsigned Q_W   = $clog2(CONV_WINS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_COARSE = 3'd2,
        S_FINE   = 3'd3,
        S_TRACK  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [WIN_LOG2-1:0]  win_cnt;
    logic [ACC_W-1:0]     acc;
    logic [Q_W-1:0]       qual;
    logic [FL_W-1:0]      flush_cnt;

    logic [MAG_W-1:0]     mag;
    logic [ACC_W:0]       sum_ext;
    logic [ACC_W-1:0]     energy;
    logic                 accum;
    logic                 win_end;
    logic                 over;
    logic                 quiet;
    logic                 hit;
    logic [Q_W-1:0]       qual_inc;
    logic                 qual_full;
    logic [7:0]           mu_d;

    // Saturating magnitude: the most negative input has no positive twin.
    always_comb begin
        mag = e_in[E_W-2:0];
        if (e_in[E_W-1]) begin
            if (e_in[E_W-2:0] == '0)
                mag = '1;
            else
                mag = ~e_in[E_W-2:0] + MAG_W'(1);
        end
    end

    always_comb begin
        accum     = (state_q == S_COARSE) || (state_q == S_FINE) || (state_q == S_TRACK);
        sum_ext   = {1'b0, acc} + {{(WIN_LOG2 + 1){1'b0}}, mag};
        energy    = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        win_end   = accum && (win_cnt == '1);
        over      = energy > thr_div;
        quiet     = energy < thr_conv;
        // In TRACK the counter tallies misses; elsewhere it tallies quiet windows.
        hit       = (state_q == S_TRACK) ? !quiet : quiet;
        qual_inc  = qual + Q_W'(1);
        qual_full = hit && (qual_inc == Q_W'(CONV_WINS));
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FAULT: begin
                    if (start)
                        state_d = S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_cnt == FL_W'(FLUSH_CYC - 1))
                        state_d = S_COARSE;
                end
                S_COARSE, S_FINE, S_TRACK: begin
                    if (win_end) begin
                        if (over)
                            state_d = S_FAULT;
                        else if (qual_full) begin
                            case (state_q)
                                S_COARSE: state_d = S_FINE;
                                S_FINE:   state_d = S_TRACK;
                                default:  state_d = S_COARSE;
                            endcase
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mu_d = 8'(MU_FREEZE);
        case (state_d)
            S_COARSE: begin
                if (state_q != S_COARSE)
                    mu_d = 8'(MU_COARSE);
                else begin
`ifdef LMS_MU_ANNEAL_EN
                    mu_d = mu_out;
                    if (win_end && quiet && (mu_out < 8'(MU_FINE)))
                        mu_d = mu_out + 8'd1;
`else
                    mu_d = 8'(MU_COARSE);
`endif
                end
            end
            S_FINE, S_TRACK: mu_d = 8'(MU_FINE);
            default:         mu_d = 8'(MU_FREEZE);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_rst_n <= 1'b1;
            mu_out     <= 8'(MU_FREEZE);
            converged  <= 1'b0;
            diverged   <= 1'b0;
            win_energy <= '0;
        end else begin
            filt_rst_n <= !((state_d == S_FLUSH) || (state_d == S_FAULT));
            mu_out     <= mu_d;
            converged  <= (state_d == S_TRACK);
            diverged   <= (state_d == S_FAULT);
            if (win_end)
                win_energy <= energy;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt   <= '0;
            acc       <= '0;
            qual      <= '0;
            flush_cnt <= '0;
        end else if (state_d != state_q) begin
            win_cnt   <= '0;
            acc       <= '0;
            qual      <= '0;
            flush_cnt <= '0;
        end else begin
            if (accum) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (win_end) begin
                    acc  <= '0;
                    qual <= hit ? qual_inc : '0;
                end else begin
                    acc <= energy;
                end
            end
            if (state_q == S_FLUSH)
                flush_cnt <= flush_cnt + FL_W'(1);
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Self-checking bench for lms_adapt_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of the training schedule.
module tb_lms_adapt_ctrl;

    localparam longint MAXA    = 64'd4294967295;     // 2**32-1
    localparam longint ACC_MAX = 64'd274877906943;   // 2**38-1

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic signed [32:0] e_in = '0;
    logic [37:0]        thr_conv = 38'd100;
    logic [37:0]        thr_div = 38'd10000;
    logic               filt_rst_n;
    logic [7:0]         mu_out;
    logic [2:0]         state_out;
    logic               converged;
    logic               diverged;
    logic [37:0]        win_energy;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    lms_adapt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .e_in       (e_in),
        .thr_conv   (thr_conv),
        .thr_div    (thr_div),
        .filt_rst_n (filt_rst_n),
        .mu_out     (mu_out),
        .state_out  (state_out),
        .converged  (converged),
        .diverged   (diverged),
        .win_energy (win_energy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint abs_sat(input logic signed [32:0] e);
        longint v;
        v = e;
        if (v < 0) v = -v;
        if (v > MAXA) v = MAXA;
        return v;
    endfunction

    // Behavioural model: state index, cycles spent in the state, running window sum.
    int     m_state = 0;
    int     m_cnt = 0;
    longint m_sum = 0;
    int     m_qual = 0;
    int     m_mu = 40;
    longint m_energy = 0;
    int     nxt;
    bit     we;
    longint en;
    bit     counts;
    bit     anneal;

    initial begin
        anneal = 1'b0;
`ifdef LMS_MU_ANNEAL_EN
        anneal = 1'b1;
`endif
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_cnt = 0; m_sum = 0; m_qual = 0; m_mu = 40; m_energy = 0;
        end else begin
            nxt = m_state;
            we = 1'b0;
            en = 0;
            if (m_state >= 2 && m_state <= 4) begin
                m_sum = m_sum + abs_sat(e_in);
                if (m_sum > ACC_MAX) m_sum = ACC_MAX;
                if (m_cnt % 64 == 63) begin
                    we = 1'b1;
                    en = m_sum;
                    m_energy = m_sum;
                    m_sum = 0;
                end
            end
            if (abort) nxt = 0;
            else if (m_state == 1) begin
                if (m_cnt == 15) nxt = 2;
            end else if (we) begin
                if (en > longint'(thr_div)) nxt = 5;
                else begin
                    counts = (m_state == 4) ? (en >= longint'(thr_conv)) : (en < longint'(thr_conv));
                    if (counts) m_qual++; else m_qual = 0;
                    if (m_qual == 4) nxt = (m_state == 4) ? 2 : m_state + 1;
                    else if (anneal && m_state == 2 && en < longint'(thr_conv) && m_mu < 8) m_mu++;
                end
            end else if ((m_state == 0 || m_state == 5) && start) nxt = 1;

            if (nxt != m_state) begin
                m_state = nxt; m_cnt = 0; m_sum = 0; m_qual = 0;
                m_mu = (nxt == 2) ? 4 : (nxt == 3 || nxt == 4) ? 8 : 40;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", longint'(state_out), m_state);
            check("filt_rst_n", longint'(filt_rst_n), (m_state == 1 || m_state == 5) ? 0 : 1);
            check("mu", longint'(mu_out), m_mu);
            check("converged", longint'(converged), (m_state == 4) ? 1 : 0);
            check("diverged", longint'(diverged), (m_state == 5) ? 1 : 0);
            check("win_energy", longint'(win_energy), m_energy);
        end
    end

    task automatic count_state(input int s, output int n);
        n = 0;
        while (int'(state_out) == s && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_flush(output int n);
        n = 0;
        while (filt_rst_n == 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        longint ev;
        int mag;
        int mode;

        #3 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", longint'(state_out), 0);
        check("rst_mu", longint'(mu_out), 40);
        check("rst_filt", longint'(filt_rst_n), 1);
        check("rst_energy", longint'(win_energy), 0);
        reset = 1'b1;
        @(negedge clk);

        // Full training with silent error.
        e_in = '0; thr_conv = 38'd100; thr_div = 38'd10000;
        pulse_start();
        check("s2_flush_state", longint'(state_out), 1);
        count_flush(n);
        check("s2_flush_len", n, 16);
        check("s2_coarse_mu", longint'(mu_out), 4);
        count_state(2, n);
        check("s2_coarse_len", n, 256);
        check("s2_fine_state", longint'(state_out), 3);
        check("s2_fine_mu", longint'(mu_out), 8);
        count_state(3, n);
        check("s2_fine_len", n, 256);
        check("s2_track_conv", longint'(converged), 1);

        // TRACK misses back to COARSE.
        e_in = 33'sd500; thr_div = 38'd1000000;
        repeat (64) @(negedge clk);
        check("s4_energy", longint'(win_energy), 32000);
        count_state(4, n);
        check("s4_track_rest", n, 192);
        check("s4_coarse_state", longint'(state_out), 2);
        check("s4_conv_low", longint'(converged), 0);

        // Saturated error diverges at the first window end.
        e_in = 33'sh1_0000_0000; thr_div = 38'd1000;
        count_state(2, n);
        check("s3_len", n, 64);
        check("s3_state", longint'(state_out), 5);
        check("s3_div", longint'(diverged), 1);
        check("s3_filt", longint'(filt_rst_n), 0);
        check("s3_mu", longint'(mu_out), 40);
        check("s3_energy", longint'(win_energy), 64'd274877906880);

        // Restart from FAULT, then abort on the qualifying window end.
        e_in = 33'sd1; thr_div = 38'd10000; thr_conv = 38'd100;
        pulse_start();
        check("s5_flush", longint'(state_out), 1);
        check("s5_div_low", longint'(diverged), 0);
        count_flush(n);
        repeat (255) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s5_abort_state", longint'(state_out), 0);
        check("s5_abort_mu", longint'(mu_out), 40);
        check("s5_abort_energy", longint'(win_energy), 64);

        // mu schedule through COARSE.
        e_in = '0;
        pulse_start();
        count_flush(n);
        check("s6_mu0", longint'(mu_out), 4);
        for (int w = 1; w <= 3; w++) begin
            repeat (64) @(negedge clk);
            check("s6_mu_win", longint'(mu_out), anneal ? 4 + w : 4);
        end
        repeat (64) @(negedge clk);
        check("s6_fine_state", longint'(state_out), 3);
        check("s6_fine_mu", longint'(mu_out), 8);

        // Asynchronous reset mid-TRACK.
        count_state(3, n);
        check("s1_fine_len", n, 256);
        e_in = 33'sd1;
        repeat (70) @(negedge clk);
        check("s1_energy_pre", longint'(win_energy), 64);
        #2 reset = 1'b0;
        #1;
        check("s1_state", longint'(state_out), 0);
        check("s1_mu", longint'(mu_out), 40);
        check("s1_filt", longint'(filt_rst_n), 1);
        check("s1_conv", longint'(converged), 0);
        check("s1_energy", longint'(win_energy), 0);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic.
        mag = 0;
        for (int c = 0; c < 5000; c++) begin
            if (c % 100 == 0) begin
                mode = $urandom_range(0, 5);
                case (mode)
                    0: mag = 0;
                    1: mag = 1;
                    2: mag = 3;
                    3: mag = 200;
                    default: mag = 1 << 20;
                endcase
            end
            if (c % 500 == 0) begin
                thr_conv = 38'($urandom_range(50, 400));
                thr_div  = 38'($urandom_range(300, 100000));
            end
            ev = longint'($urandom_range(0, mag));
            if ($urandom_range(0, 1) == 1) ev = -ev;
            if (mode == 5 && $urandom_range(0, 7) == 0) ev = -64'sd4294967296;
            e_in  = 33'(ev);
            start = ($urandom_range(0, 29) == 0);
            abort = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
